// File: rtl/ex_stage_pkg.sv
// Shared constants and state encoding for the execute stage.
package ex_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CB_W = 10;
  localparam int unsigned FN_W = 6;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FN_W-1:0] FN_MULT = 6'h18;

  localparam int unsigned CB_ALUSRC = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier: consumes MUL_BITS_PER_CYCLE multiplier bits per step,
// keeping only the low XLEN bits of the product.
module ex_stage_iter_mul
  import ex_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic [XLEN-1:0] result_c,
  output logic            done_c
);

  localparam int unsigned MUL_CYCLES = XLEN / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W      = $clog2(MUL_CYCLES + 1);

  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  acc;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  partial;

  // result_c already includes this step's partial product, so the last step's value is final.
  always_comb begin
    partial  = XLEN'(mcand * XLEN'(mplier[MUL_BITS_PER_CYCLE-1:0]));
    result_c = acc + (partial << (MUL_BITS_PER_CYCLE * 32'(count)));
    done_c   = (count == CNT_W'(MUL_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= result_c;
      mplier <= mplier >> MUL_BITS_PER_CYCLE;
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative MULT that stalls upstream while it runs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inValid,
  input  logic [XLEN-1:0] inR1,
  input  logic [XLEN-1:0] inR2,
  input  logic [XLEN-1:0] inAddress,
  input  logic [1:0]      inAluCtrl,
  input  logic [CB_W-1:0] inControlBits,
  output logic            stall,
  output logic            outValid,
  output logic [XLEN-1:0] outAluResult,
  output logic            outZero,
  output logic [XLEN-1:0] outR2,
  output logic [CB_W-1:0] outControlBits
);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] op_b_c;
  logic [XLEN-1:0] alu_c;
  logic [FN_W-1:0] funct_c;
  logic            is_mult_c;
  logic [XLEN-1:0] mul_result_c;
  logic            mul_done_c;
  logic            mul_start;
  logic            mul_step;
  logic            load_alu;
  logic            load_mul;
  logic            latch_pass;
  logic            valid_next;

  // Single-cycle ALU datapath.
  always_comb begin
    op_b_c    = inControlBits[CB_ALUSRC] ? inAddress : inR2;
    funct_c   = inAddress[FN_W-1:0];
    is_mult_c = (inAluCtrl == ALU_RTYPE) && (funct_c == FN_MULT);
    alu_c     = '0;
    case (inAluCtrl)
      ALU_ADD: alu_c = inR1 + op_b_c;
      ALU_SUB: alu_c = inR1 - op_b_c;
      ALU_ORI: alu_c = inR1 | inAddress;
      default: begin
        case (funct_c)
          FN_ADD:  alu_c = inR1 + op_b_c;
          FN_SUB:  alu_c = inR1 - op_b_c;
          FN_AND:  alu_c = inR1 & op_b_c;
          FN_OR:   alu_c = inR1 | op_b_c;
          FN_SLT:  alu_c = {{(XLEN-1){1'b0}}, ($signed(inR1) < $signed(op_b_c))};
          default: alu_c = '0;
        endcase
      end
    endcase
  end

  ex_stage_iter_mul #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_iter_mul (
    .clock    (clock),
    .reset    (reset),
    .start    (mul_start),
    .step     (mul_step),
    .mcand_in (inR1),
    .mplier_in(op_b_c),
    .result_c (mul_result_c),
    .done_c   (mul_done_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, stall and register-load strobes; stall drops in the last MUL cycle.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    latch_pass = 1'b0;
    valid_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inValid) begin
          latch_pass = 1'b1;
          if (is_mult_c) begin
            stall      = 1'b1;
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else begin
            load_alu   = 1'b1;
            valid_next = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        stall    = ~mul_done_c;
        if (mul_done_c) begin
          load_mul   = 1'b1;
          valid_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outValid       <= 1'b0;
      outAluResult   <= '0;
      outZero        <= 1'b0;
      outR2          <= '0;
      outControlBits <= '0;
    end else begin
      outValid <= valid_next;
      if (load_alu) begin
        outAluResult <= alu_c;
        outZero      <= (alu_c == '0);
      end else if (load_mul) begin
        outAluResult <= mul_result_c;
        outZero      <= (mul_result_c == '0);
      end
      if (latch_pass) begin
        outR2          <= inR2;
        outControlBits <= inControlBits;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized traffic vs. a timing model.
module tb_ex_stage;

  localparam int MUL_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] inR1 = '0;
  logic [31:0] inR2 = '0;
  logic [31:0] inAddress = '0;
  logic [1:0]  inAluCtrl = '0;
  logic [9:0]  inControlBits = '0;
  logic        stall;
  logic        outValid;
  logic [31:0] outAluResult;
  logic        outZero;
  logic [31:0] outR2;
  logic [9:0]  outControlBits;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  ex_stage dut (
    .clock         (clock),
    .reset         (reset),
    .inValid       (inValid),
    .inR1          (inR1),
    .inR2          (inR2),
    .inAddress     (inAddress),
    .inAluCtrl     (inAluCtrl),
    .inControlBits (inControlBits),
    .stall         (stall),
    .outValid      (outValid),
    .outAluResult  (outAluResult),
    .outZero       (outZero),
    .outR2         (outR2),
    .outControlBits(outControlBits)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the opcode table; product taken at 64 bits, low half kept.
  function automatic logic [31:0] ref_alu(input logic [1:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] r2, input logic [31:0] imm,
                                          input logic src);
    logic [31:0] b;
    logic [63:0] p;
    b = src ? imm : r2;
    case (ctrl)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | imm;
      default: begin
        case (imm[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: begin
            p = {32'd0, a} * {32'd0, b};
            return p[31:0];
          end
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // Timing model: age = -1 when idle, else index (1..MUL_CYCLES) of the current MUL cycle.
  int          age = -1;
  logic [31:0] pend;
  logic [31:0] e_res;
  logic [31:0] e_r2;
  logic        e_valid;
  logic        e_zero;
  logic [9:0]  e_cb;

  always @(negedge clock) begin
    logic e_stall;
    logic mult;
    mult = inValid && (inAluCtrl == 2'd2) && (inAddress[5:0] == 6'h18);
    if (reset)        e_stall = 1'b0;
    else if (age < 0) e_stall = mult;
    else              e_stall = (age < MUL_CYCLES);
    if (armed) begin
      cmp("m_valid", 32'(outValid), 32'(e_valid));
      cmp("m_result", outAluResult, e_res);
      cmp("m_zero", 32'(outZero), 32'(e_zero));
      cmp("m_r2", outR2, e_r2);
      cmp("m_cb", 32'(outControlBits), 32'(e_cb));
      cmp("m_stall", 32'(stall), 32'(e_stall));
    end
    if (reset) begin
      e_valid = 1'b0; e_res = '0; e_zero = 1'b0; e_r2 = '0; e_cb = '0;
      age = -1;
      armed = 1'b1;
    end else if (age < 0) begin
      if (!inValid) begin
        e_valid = 1'b0;
      end else begin
        e_r2 = inR2;
        e_cb = inControlBits;
        if (mult) begin
          pend    = ref_alu(inAluCtrl, inR1, inR2, inAddress, inControlBits[0]);
          e_valid = 1'b0;
          age     = 1;
        end else begin
          e_res   = ref_alu(inAluCtrl, inR1, inR2, inAddress, inControlBits[0]);
          e_zero  = (e_res == 32'd0);
          e_valid = 1'b1;
        end
      end
    end else if (age == MUL_CYCLES) begin
      e_valid = 1'b1;
      e_res   = pend;
      e_zero  = (pend == 32'd0);
      age     = -1;
    end else begin
      e_valid = 1'b0;
      age++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present an instruction and hold it until the stage stops stalling; reports stall cycles.
  task automatic issue(input logic [1:0] ctrl, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] addr, input logic src, output int stalls);
    inValid       = 1'b1;
    inAluCtrl     = ctrl;
    inR1          = r1;
    inR2          = r2;
    inAddress     = addr;
    inControlBits = {9'($urandom), src};
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall) return;
      stalls++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL issue_timeout: stall still %b after %0d cycles", stall, stalls);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s;
    logic last_stall;
    logic [5:0] fn;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cmp("rst_valid", 32'(outValid), 32'd0);
    cmp("rst_result", outAluResult, 32'd0);
    cmp("rst_r2", outR2, 32'd0);

    issue(2'd0, 32'd5, 32'd7, 32'd0, 1'b0, s);
    cmp("add_stalls", 32'(s), 32'd0);
    step();
    cmp("add_result", outAluResult, 32'd12);
    cmp("add_valid", 32'(outValid), 32'd1);
    cmp("add_zero", 32'(outZero), 32'd0);

    issue(2'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 1'b0, s);
    step();
    cmp("slt_result", outAluResult, 32'd1);

    issue(2'd1, 32'd3, 32'd3, 32'd0, 1'b0, s);
    step();
    cmp("sub_result", outAluResult, 32'd0);
    cmp("sub_zero", 32'(outZero), 32'd1);

    issue(2'd0, 32'h7FFF_FFFF, 32'h55, 32'd1, 1'b1, s);
    step();
    cmp("wrap_result", outAluResult, 32'h8000_0000);

    issue(2'd3, 32'hF0, 32'h1234, 32'h0F, 1'b0, s);
    step();
    cmp("ori_result", outAluResult, 32'hFF);

    issue(2'd2, 32'h0001_2345, 32'h100, 32'h18, 1'b0, s);
    cmp("mult_stalls", 32'(s), 32'd4);
    step();
    cmp("mult_valid", 32'(outValid), 32'd1);
    cmp("mult_result", outAluResult, 32'h0123_4500);
    issue(2'd0, 32'd1, 32'd2, 32'd0, 1'b0, s);
    step();
    cmp("queued_add", outAluResult, 32'd3);
    cmp("queued_valid", 32'(outValid), 32'd1);

    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18, 1'b0, s);
    step();
    cmp("mult_ff", outAluResult, 32'd1);

    issue(2'd2, 32'd9, 32'd9, 32'h3F, 1'b0, s);
    step();
    cmp("bad_funct_res", outAluResult, 32'd0);
    cmp("bad_funct_valid", 32'(outValid), 32'd1);

    // Abort a MULT in its second iteration.
    issue(2'd2, 32'd6, 32'd7, 32'h18, 1'b0, s);
    inValid = 1'b0;
    step();
    inValid = 1'b1;
    inAluCtrl = 2'd2; inR1 = 32'd6; inR2 = 32'd7; inAddress = 32'h18; inControlBits = 10'h3FE;
    step();
    step();
    reset   = 1'b1;
    inValid = 1'b0;
    #1;
    cmp("rst_mid_stall", 32'(stall), 32'd0);
    step();
    reset = 1'b0;
    cmp("rst_mid_valid", 32'(outValid), 32'd0);
    cmp("rst_mid_result", outAluResult, 32'd0);
    cmp("rst_mid_cb", 32'(outControlBits), 32'd0);
    issue(2'd0, 32'd20, 32'd22, 32'd0, 1'b0, s);
    cmp("post_rst_stalls", 32'(s), 32'd0);
    step();
    cmp("post_rst_add", outAluResult, 32'd42);

    // Randomized traffic; inputs held whenever the stage stalled last cycle.
    inValid = 1'b0;
    last_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        inValid       = ($urandom_range(0, 9) != 0);
        inAluCtrl     = 2'($urandom);
        inR1          = pick_op();
        inR2          = pick_op();
        inAddress     = pick_op();
        inControlBits = 10'($urandom);
        if (inAluCtrl == 2'd2) begin
          case ($urandom_range(0, 7))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            5, 6: fn = 6'h18;
            default: fn = 6'($urandom);
          endcase
          inAddress[5:0] = fn;
        end
      end
      #1;
      last_stall = stall;
    end
    reset   = 1'b0;
    inValid = 1'b0;
    repeat (8) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
